// File: rtl/spawn_scheduler.sv
// Tile spawn scheduler for a four-column rhythm game.
// Tracks score, lives and level, and picks spawn columns with an LFSR.
module spawn_scheduler #(
    parameter int INIT_INTERVAL  = 60,
    parameter int MIN_INTERVAL   = 20,
    parameter int INTERVAL_STEP  = 5,
    parameter int HITS_PER_LEVEL = 10,
    parameter int START_LIVES    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [3:0]  col_active,
    input  logic [3:0]  col_hit,
    input  logic [3:0]  col_miss,
    output logic [3:0]  spawn,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [1:0]  state,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [7:0] INIT_I = 8'(INIT_INTERVAL);
    localparam logic [7:0] MIN_I  = 8'(MIN_INTERVAL);
    localparam logic [7:0] STEP_I = 8'(INTERVAL_STEP);
    localparam logic [8:0] FLOOR  = 9'(MIN_INTERVAL + INTERVAL_STEP);
    localparam logic [7:0] HPL    = 8'(HITS_PER_LEVEL);
    localparam logic [1:0] LIVES0 = 2'(START_LIVES);

    state_t      cur;
    state_t      nxt;
    logic [7:0]  lfsr;
    logic [7:0]  frame_cnt;
    logic [7:0]  interval;
    logic [7:0]  hit_cnt;

    logic        samp;
    logic [2:0]  hit_n;
    logic [2:0]  miss_n;
    logic [16:0] score_sum;
    logic [15:0] score_n;
    logic [7:0]  hc_sum;
    logic        lvl_up;
    logic [7:0]  interval_dn;
    logic        dec;
    logic [1:0]  lives_n;
    logic        dead;
    logic [1:0]  cand;
    logic [1:0]  idx;
    logic [1:0]  col;
    logic        found;
    logic        lfsr_fb;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        pop4 = {2'b0, v[0]} + {2'b0, v[1]}
             + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

    assign state     = cur;
    assign game_over = (cur == S_OVER);
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Per-tick arithmetic: score, hit counter, interval, lives, timer
    always_comb begin
        samp      = frame_tick && (cur == S_PLAY);
        hit_n     = pop4(col_hit);
        miss_n    = pop4(col_miss);
        score_sum = {1'b0, score} + {14'b0, hit_n};
        score_n   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        hc_sum    = hit_cnt + {5'b0, hit_n};
        lvl_up    = (hc_sum >= HPL);
        interval_dn = MIN_I;
        if ({1'b0, interval} >= FLOOR)
            interval_dn = interval - STEP_I;
        dec     = samp && (frame_cnt >= interval - 8'd1);
        lives_n = 2'd0;
        if ({1'b0, lives} > miss_n)
            lives_n = lives - miss_n[1:0];
        dead = samp && (lives_n == 2'd0);
    end

    // Column pick: LFSR candidate first, then probe upward for a free one
    always_comb begin
        cand  = lfsr[1:0];
        idx   = cand;
        col   = cand;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = cand + 2'(k);
            if (!found && !col_active[idx]) begin
                found = 1'b1;
                col   = idx;
            end
        end
    end

    // Game FSM next-state
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE:  if (start) nxt = S_PLAY;
            S_PLAY:  if (dead) nxt = S_OVER;
            S_OVER:  if (start) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Game FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= S_IDLE;
        else          cur <= nxt;
    end

    // Game datapath: LFSR, counters, score/lives/level, spawn register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr      <= 8'hA5;
            spawn     <= 4'd0;
            score     <= 16'd0;
            lives     <= 2'd0;
            level     <= 4'd0;
            frame_cnt <= 8'd0;
            hit_cnt   <= 8'd0;
            interval  <= INIT_I;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            if (cur == S_IDLE && start) begin
                spawn     <= 4'd0;
                score     <= 16'd0;
                lives     <= LIVES0;
                level     <= 4'd0;
                frame_cnt <= 8'd0;
                hit_cnt   <= 8'd0;
                interval  <= INIT_I;
            end else if (samp) begin
                score     <= score_n;
                lives     <= lives_n;
                frame_cnt <= dec ? 8'd0 : frame_cnt + 8'd1;
                hit_cnt   <= lvl_up ? hc_sum - HPL : hc_sum;
                if (lvl_up) begin
                    if (level != 4'd15) level <= level + 4'd1;
                    interval <= interval_dn;
                end
                if (dec && found && !dead)
                    spawn <= 4'b0001 << col;
                else
                    spawn <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Randomised scoreboard bench for spawn_scheduler.
// A game-level reference model predicts outputs for each clock.
module tb_spawn_scheduler;

    logic        clk;
    logic        reset_n;
    logic        frame_tick;
    logic        start;
    logic [3:0]  col_active;
    logic [3:0]  col_hit;
    logic [3:0]  col_miss;
    logic [3:0]  spawn;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [1:0]  state;
    logic        game_over;

    spawn_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start      (start),
        .col_active (col_active),
        .col_hit    (col_hit),
        .col_miss   (col_miss),
        .spawn      (spawn),
        .score      (score),
        .lives      (lives),
        .level      (level),
        .state      (state),
        .game_over  (game_over)
    );

    typedef struct {
        logic [3:0]  spawn;
        logic [15:0] score;
        logic [1:0]  lives;
        logic [3:0]  level;
        logic [1:0]  state;
        logic        game_over;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_rn = 1'b0;

    int m_state, m_spawn, m_score, m_lives, m_level;
    int m_fcnt, m_hcnt, m_int, m_lfsr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h exp %0h",
                     nm, cyc, got, exp);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 8'hFF;
    endfunction

    // Reference model: advances one clock given the inputs
    task automatic model(input logic rn, input logic st,
                         input logic tk, input logic [3:0] act,
                         input logic [3:0] hit, input logic [3:0] miss);
        int h, m, c, ns;
        bit dec, got;
        if (!rn) begin
            m_state = 0; m_spawn = 0; m_score = 0;
            m_lives = 0; m_level = 0; m_fcnt = 0;
            m_hcnt = 0; m_int = 60; m_lfsr = 8'hA5;
            return;
        end
        case (m_state)
            0: if (st) begin
                m_state = 1; m_score = 0; m_lives = 3;
                m_level = 0; m_int = 60; m_fcnt = 0;
                m_hcnt = 0; m_spawn = 0;
            end
            1: if (tk) begin
                h = $countones(hit);
                m = $countones(miss);
                dec = (m_fcnt >= m_int - 1);
                m_fcnt = dec ? 0 : m_fcnt + 1;
                m_score = m_score + h;
                if (m_score > 65535) m_score = 65535;
                m_hcnt = m_hcnt + h;
                if (m_hcnt >= 10) begin
                    m_hcnt = m_hcnt - 10;
                    if (m_level < 15) m_level++;
                    m_int = m_int - 5;
                    if (m_int < 20) m_int = 20;
                end
                ns = 0;
                got = 0;
                if (dec)
                    for (int k = 0; k < 4; k++) begin
                        c = ((m_lfsr % 4) + k) % 4;
                        if (!got && !act[c]) begin
                            got = 1;
                            ns = 1 << c;
                        end
                    end
                m_lives = (m_lives > m) ? m_lives - m : 0;
                if (m_lives == 0) begin
                    m_state = 2;
                    ns = 0;
                end
                m_spawn = ns;
            end
            default: if (st) m_state = 0;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic step(input logic rn, input logic st,
                        input logic tk, input logic [3:0] act,
                        input logic [3:0] hit, input logic [3:0] miss);
        exp_t e;
        @(negedge clk);
        reset_n = rn; start = st; frame_tick = tk;
        col_active = act; col_hit = hit; col_miss = miss;
        if (!rn && prev_rn) begin
            #1;
            chk("async_spawn", int'(spawn), 0);
            chk("async_state", int'(state), 0);
            chk("async_score", int'(score), 0);
        end
        prev_rn = rn;
        model(rn, st, tk, act, hit, miss);
        e.spawn = 4'(m_spawn);
        e.score = 16'(m_score);
        e.lives = 2'(m_lives);
        e.level = 4'(m_level);
        e.state = 2'(m_state);
        e.game_over = (m_state == 2);
        q.push_back(e);
    endtask

    task automatic idle();
        step(1, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic tick(input logic [3:0] act, input logic [3:0] hit,
                        input logic [3:0] miss);
        step(1, 0, 1, act, hit, miss);
    endtask

    task automatic run_to_decision();
        for (int i = 0; i < 300 && m_fcnt != m_int - 1; i++)
            tick(4'h0, 4'h0, 4'h0);
    endtask

    // Monitor: compare DUT outputs after each edge against the queue
    always @(posedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("spawn", int'(spawn), int'(e.spawn));
            chk("score", int'(score), int'(e.score));
            chk("lives", int'(lives), int'(e.lives));
            chk("level", int'(level), int'(e.level));
            chk("state", int'(state), int'(e.state));
            chk("game_over", int'(game_over), int'(e.game_over));
            if ($countones(spawn) > 1) chk("onehot", 1, 0);
        end
    end

    initial begin
        reset_n = 0; start = 0; frame_tick = 0;
        col_active = 0; col_hit = 0; col_miss = 0;
        repeat (3) step(0, 0, 0, 4'h0, 4'h0, 4'h0);
        idle();
        // First game: 60 ticks to first spawn, then 61st clears it
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 61; i++) begin
            tick(4'h0, 4'h0, 4'h0);
            idle();
        end
        // start ignored during play
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        // Fully occupied board at decision: no spawn
        for (int i = 0; i < 300 && m_fcnt != m_int - 1; i++)
            tick(4'h0, 4'h0, 4'h0);
        tick(4'hF, 4'h0, 4'h0);
        idle();
        // Candidate 3 busy with 4'b1011: probe lands on column 2
        for (int i = 0; i < 300 && m_fcnt != m_int - 2; i++)
            tick(4'h0, 4'h0, 4'h0);
        tick(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 64 && (m_lfsr & 3) != 3; i++) idle();
        tick(4'b1011, 4'h0, 4'h0);
        idle();
        // Ten single hits: level 1, interval shrinks to 55
        for (int i = 0; i < 10; i++) tick(4'h0, 4'b0001, 4'h0);
        run_to_decision();
        tick(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 56; i++) tick(4'h0, 4'h0, 4'h0);
        // Hit and three misses together end the game
        tick(4'h0, 4'b1000, 4'b0111);
        idle();
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        idle();
        step(1, 1, 0, 4'h0, 4'h0, 4'h0);
        // Long game: saturate score, level and interval
        for (int i = 0; i < 16400; i++)
            tick(4'($urandom), 4'hF, 4'h0);
        // Reset while a spawn is pending
        run_to_decision();
        tick(4'h0, 4'h0, 4'h0);
        idle();
        step(0, 0, 0, 4'h0, 4'h0, 4'h0);
        step(0, 0, 0, 4'h0, 4'h0, 4'h0);
        idle();
        // Random games
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] h, m;
            h = 4'($urandom) & 4'($urandom);
            m = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
            step(($urandom_range(0, 999) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom), h, m);
        end
        idle();
        idle();
        @(posedge clk);
        #4;
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
